// File: rtl/npu_alu_pkg.sv
// Shared widths, opcodes, FSM states and saturation helpers for the NPU compute stage.
package npu_alu_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned LENW = 10;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned ACCW = 2 * DW + LENW;

  localparam logic [DW-1:0] SatMax = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SatMin = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    OpAdd   = 3'd0,
    OpSub   = 3'd1,
    OpMul   = 3'd2,
    OpMac   = 3'd3,
    OpRelu  = 3'd4,
    OpMax   = 3'd5,
    OpPass0 = 3'd6,
    OpPass1 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDump = 2'd2
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [LENW-1:0] len;
    logic [3:0]      shift;
  } cfg_t;

  // Clamp a DW+1 bit signed sum/difference into DW bits.
  function automatic logic [DW-1:0] sat_sum(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) begin
      return v[DW] ? SatMin : SatMax;
    end
    return v[DW-1:0];
  endfunction

endpackage

// File: rtl/npu_rsat.sv
// Combinational round-half-up, arithmetic right shift and saturation from ACCW to DW bits.
module npu_rsat
  import npu_alu_pkg::*;
(
  input  logic [ACCW-1:0] val_i,
  input  logic [3:0]      shift_i,
  output logic [DW-1:0]   res_o
);

  logic signed [ACCW:0] rounded;
  logic signed [ACCW:0] shifted;

  always_comb begin
    // One guard bit keeps the rounding add from wrapping at the extremes.
    rounded = {val_i[ACCW-1], val_i};
    if (shift_i != 4'd0) begin
      rounded = rounded + ((ACCW + 1)'(1) << (shift_i - 4'd1));
    end
    shifted = rounded >>> shift_i;
    if ((&shifted[ACCW:DW-1]) || !(|shifted[ACCW:DW-1])) begin
      res_o = shifted[DW-1:0];
    end else begin
      res_o = shifted[ACCW] ? SatMin : SatMax;
    end
  end

endmodule

// File: rtl/npu_alu.sv
// NPU compute stage: two-stage element-wise pipeline plus a MAC reduction FSM.
module npu_alu
  import npu_alu_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET_X,
  input  logic            SOFT_RESET,
  input  logic [2:0]      OP_MODE,
  input  logic [LENW-1:0] ACC_LEN,
  input  logic [3:0]      SHIFT,
  input  logic            NPU_EN,
  input  logic [DW-1:0]   A_RDATA,
  input  logic [DW-1:0]   B_RDATA,
  output logic            LM_EN,
  output logic [DW-1:0]   C_WDATA,
  output logic            BUSY
);

  cfg_t                   cfg_q, cfg_d, cfg_eff;
  state_e                 state_q, state_d;
  logic [LENW-1:0]        cnt_q, cnt_d, grp_cnt, len_eff;
  logic signed [ACCW-1:0] acc_q, acc_d, grp_acc;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [DW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [DW:0]            s1_sum_q, s1_sum_d;
  logic signed [PW-1:0]   s1_prod_q, s1_prod_d;
  logic                   lm_en_q, lm_en_d, busy_q, busy_d;
  logic [DW-1:0]          c_q, c_d;

  logic signed [DW-1:0]   a_s, b_s;
  logic signed [PW-1:0]   prod;
  logic                   is_mac;
  logic [ACCW-1:0]        rsat_in;
  logic [DW-1:0]          rsat_res;

  assign a_s  = A_RDATA;
  assign b_s  = B_RDATA;
  assign prod = PW'(a_s) * PW'(b_s);

  // The input that starts a new job sees the live config; later ones see the latched copy.
  assign cfg_eff = busy_q ? cfg_q : '{op: op_e'(OP_MODE), len: ACC_LEN, shift: SHIFT};
  assign len_eff = (cfg_eff.len == '0) ? LENW'(1) : cfg_eff.len;
  assign is_mac  = (cfg_eff.op == OpMac);

  assign rsat_in = (state_q == StDump) ? acc_q : ACCW'(s1_prod_q);

  npu_rsat u_rsat (
    .val_i   (rsat_in),
    .shift_i (cfg_q.shift),
    .res_o   (rsat_res)
  );

  always_comb begin
    cfg_d      = (NPU_EN && !busy_q) ? cfg_eff : cfg_q;
    s1_valid_d = NPU_EN && !is_mac;
    s1_a_d     = a_s;
    s1_b_d     = b_s;
    s1_sum_d   = (cfg_eff.op == OpSub) ? ({a_s[DW-1], a_s} - {b_s[DW-1], b_s})
                                       : ({a_s[DW-1], a_s} + {b_s[DW-1], b_s});
    s1_prod_d  = prod;

    // A new group starts from zero unless we are mid-accumulation.
    grp_acc = (state_q == StAcc) ? acc_q : '0;
    grp_cnt = (state_q == StAcc) ? cnt_q : '0;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (NPU_EN && is_mac) begin
      acc_d   = grp_acc + ACCW'(prod);
      cnt_d   = grp_cnt + LENW'(1);
      state_d = (cnt_d == len_eff) ? StDump : StAcc;
    end else if (state_q == StDump) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = StIdle;
    end

    lm_en_d = s1_valid_q || (state_q == StDump);
    c_d     = c_q;
    if (state_q == StDump) begin
      c_d = rsat_res;
    end else if (s1_valid_q) begin
      unique case (cfg_q.op)
        OpAdd, OpSub: c_d = sat_sum(s1_sum_q);
        OpMul:        c_d = rsat_res;
        OpRelu:       c_d = s1_a_q[DW-1] ? '0 : s1_a_q;
        OpMax:        c_d = (s1_a_q > s1_b_q) ? s1_a_q : s1_b_q;
        default:      c_d = s1_a_q;
      endcase
    end

    busy_d = NPU_EN || s1_valid_q || lm_en_q || (state_q != StIdle);

    if (!SOFT_RESET) begin
      cfg_d      = '{op: OpAdd, len: '0, shift: '0};
      s1_valid_d = 1'b0;
      s1_a_d     = '0;
      s1_b_d     = '0;
      s1_sum_d   = '0;
      s1_prod_d  = '0;
      state_d    = StIdle;
      acc_d      = '0;
      cnt_d      = '0;
      lm_en_d    = 1'b0;
      c_d        = '0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      cfg_q      <= '{op: OpAdd, len: '0, shift: '0};
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sum_q   <= '0;
      s1_prod_q  <= '0;
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      lm_en_q    <= 1'b0;
      c_q        <= '0;
      busy_q     <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sum_q   <= s1_sum_d;
      s1_prod_q  <= s1_prod_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      lm_en_q    <= lm_en_d;
      c_q        <= c_d;
      busy_q     <= busy_d;
    end
  end

  assign LM_EN   = lm_en_q;
  assign C_WDATA = c_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_npu_alu.sv
// Self-checking bench for npu_alu: vector table, directed MAC/reset sequences, random streams.
module tb_npu_alu;

  logic       CLK = 1'b0;
  logic       RESET_X, SOFT_RESET, NPU_EN;
  logic [2:0] OP_MODE;
  logic [9:0] ACC_LEN;
  logic [3:0] SHIFT;
  logic [7:0] A_RDATA, B_RDATA, C_WDATA;
  logic       LM_EN, BUSY;

  npu_alu dut (
    .CLK        (CLK),
    .RESET_X    (RESET_X),
    .SOFT_RESET (SOFT_RESET),
    .OP_MODE    (OP_MODE),
    .ACC_LEN    (ACC_LEN),
    .SHIFT      (SHIFT),
    .NPU_EN     (NPU_EN),
    .A_RDATA    (A_RDATA),
    .B_RDATA    (B_RDATA),
    .LM_EN      (LM_EN),
    .C_WDATA    (C_WDATA),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int op;
    int len;
    int sh;
    int a;
    int b;
    int c;
  } vec_t;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  vec_t vt[16];

  function automatic void chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int sat8(input longint v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return int'(v);
  endfunction

  function automatic int rshr(input longint v, input int sh);
    longint t = v;
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    return sat8(t >>> sh);
  endfunction

  function automatic int elem_model(input int op, input int sh, input int a, input int b);
    case (op)
      0:       return sat8(a + b);
      1:       return sat8(a - b);
      2:       return rshr(a * b, sh);
      4:       return (a < 0) ? 0 : a;
      5:       return (a > b) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Scoreboard: every LM_EN must match the head of the expected queue in cycle and value.
  initial forever begin
    bit due;
    @(negedge CLK);
    if (RESET_X) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      if (LM_EN || due) begin
        chk("lm_en", int'(LM_EN), int'(due));
        if (LM_EN && due) chk("c_wdata", int'($signed(C_WDATA)), exp_q[0].val);
        if (due) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic en, input int a, input int b);
    @(posedge CLK);
    #1;
    NPU_EN  = en;
    A_RDATA = 8'(a);
    B_RDATA = 8'(b);
  endtask

  task automatic setcfg(input int op, input int len, input int sh);
    OP_MODE = 3'(op);
    ACC_LEN = 10'(len);
    SHIFT   = 4'(sh);
  endtask

  task automatic expect_at(input int val, input int at);
    exp_t e;
    e.val = val;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || BUSY === 1'b1) && k < 64) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_busy", int'(BUSY), 0);
    exp_q.delete();
  endtask

  task automatic wait_neg(input int t);
    do @(negedge CLK); while (cyc < t);
  endtask

  initial begin
    int ops[7] = '{0, 1, 2, 4, 5, 6, 7};
    int last_e, a, b, op, sh, len, le, cnt;
    longint sum;

    vt[0]  = '{0, 0, 0,  100,  100,  127};
    vt[1]  = '{0, 0, 0, -100,  -50, -128};
    vt[2]  = '{2, 0, 4,   50,    7,   22};
    vt[3]  = '{2, 0, 0, -128, -128,  127};
    vt[4]  = '{1, 0, 0, -100,  100, -128};
    vt[5]  = '{1, 0, 0,   50,  -27,   77};
    vt[6]  = '{4, 0, 0,   -5,    9,    0};
    vt[7]  = '{4, 0, 0,   77,    9,   77};
    vt[8]  = '{5, 0, 0,   -3,   -7,   -3};
    vt[9]  = '{6, 0, 0,  -42,   11,  -42};
    vt[10] = '{2, 0, 2,   -3,    5,   -4};
    vt[11] = '{3, 0, 0,   10,   -3,  -30};
    vt[12] = '{3, 1, 6,  100,  100,  127};
    vt[13] = '{2, 0, 1,    3,    1,    2};
    vt[14] = '{2, 0, 1,   -3,    1,   -1};
    vt[15] = '{7, 0, 0,    5,  -90,    5};

    RESET_X = 1'b0;
    SOFT_RESET = 1'b1;
    NPU_EN = 1'b0;
    A_RDATA = '0;
    B_RDATA = '0;
    setcfg(0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_lm_en", int'(LM_EN), 0);
    chk("rst_c_wdata", int'(C_WDATA), 0);
    chk("rst_busy", int'(BUSY), 0);
    RESET_X = 1'b1;

    foreach (vt[i]) begin
      setcfg(vt[i].op, vt[i].len, vt[i].sh);
      step(1'b1, vt[i].a, vt[i].b);
      expect_at(vt[i].c, cyc + 2);
      step(1'b0, 0, 0);
      drain();
    end

    // MAC group of 4 with a two-cycle gap.
    setcfg(3, 4, 0);
    step(1'b1, 5, 5);
    step(1'b1, 5, 5);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    chk("mac_gap_busy", int'(BUSY), 1);
    step(1'b1, 5, 5);
    step(1'b1, 5, 5);
    expect_at(100, cyc + 2);
    step(1'b0, 0, 0);
    drain();

    // Back-to-back MAC groups of 3.
    setcfg(3, 3, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1, i);
      if (i == 3) expect_at(6, cyc + 2);
      if (i == 6) expect_at(15, cyc + 2);
    end
    step(1'b0, 0, 0);
    drain();

    // RELU then MAX streams, with BUSY tail check after RELU.
    for (int m = 0; m < 2; m++) begin
      setcfg((m == 0) ? 4 : 5, 0, 0);
      for (int i = 0; i < 16; i++) begin
        a = rnd8();
        b = rnd8();
        step(1'b1, a, b);
        expect_at(elem_model((m == 0) ? 4 : 5, 0, a, b), cyc + 2);
        last_e = cyc + 2;
      end
      step(1'b0, 0, 0);
      if (m == 0) begin
        wait_neg(last_e + 1);
        chk("busy_tail_hi", int'(BUSY), 1);
        wait_neg(last_e + 2);
        chk("busy_tail_lo", int'(BUSY), 0);
        @(posedge CLK);
        #1;
      end
      drain();
    end

    // Soft reset discards a partial MAC group.
    setcfg(3, 4, 0);
    step(1'b1, 3, 3);
    step(1'b1, 3, 3);
    @(posedge CLK);
    #1;
    NPU_EN = 1'b0;
    SOFT_RESET = 1'b0;
    @(posedge CLK);
    #1;
    SOFT_RESET = 1'b1;
    chk("soft_rst_busy", int'(BUSY), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1);
    expect_at(4, cyc + 2);
    step(1'b0, 0, 0);
    drain();

    // Async reset mid-stream while an output is being presented.
    setcfg(6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10 + i, 0);
      expect_at(10 + i, cyc + 2);
    end
    #2;
    RESET_X = 1'b0;
    NPU_EN = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_lm_en", int'(LM_EN), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_c_wdata", int'(C_WDATA), 0);
    repeat (2) @(posedge CLK);
    #3;
    RESET_X = 1'b1;
    repeat (4) step(1'b0, 0, 0);
    drain();

    // Random element-wise bursts with random gaps.
    for (int bst = 0; bst < 8; bst++) begin
      op = ops[$urandom_range(0, 6)];
      sh = $urandom_range(0, 7);
      setcfg(op, 0, sh);
      for (int i = 0; i < 12; i++) begin
        a = rnd8();
        b = rnd8();
        if ($urandom_range(0, 3) != 0) begin
          step(1'b1, a, b);
          expect_at(elem_model(op, sh, a, b), cyc + 2);
        end else begin
          step(1'b0, a, b);
        end
      end
      step(1'b0, 0, 0);
      drain();
    end

    // Random MAC groups with random gaps.
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(0, 6);
      sh = $urandom_range(0, 6);
      le = (len == 0) ? 1 : len;
      setcfg(3, len, sh);
      sum = 0;
      cnt = 0;
      for (int e = 0; e < le * 3;) begin
        if ($urandom_range(0, 3) == 0) begin
          step(1'b0, 0, 0);
        end else begin
          a = rnd8();
          b = rnd8();
          step(1'b1, a, b);
          sum += a * b;
          cnt++;
          e++;
          if (cnt == le) begin
            expect_at(rshr(sum, sh), cyc + 2);
            sum = 0;
            cnt = 0;
          end
        end
      end
      step(1'b0, 0, 0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
